exc_seq: RTL and testbench

EXC_SEQ -- requirements
Module: exc_seq

---
 rtl/exc_seq_if.sv | 44 ++++
 rtl/exc_seq.sv | 140 ++++++++++++++
 tb/tb_exc_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/exc_seq_if.sv
// Signal bundle between the exception sequencer and its requesters and control-register file.
// The master side drives stall, requests and current register values; the slave side is exc_seq.
interface exc_seq_if;
  logic        hold;
  logic [47:0] pcNext;
  logic [47:0] crInPc;
  logic [47:0] crInSpc;
  logic [47:0] crInVbr;
  logic [63:0] crInSr;
  logic [63:0] crInExsr;
  logic [63:0] crInTea;
  logic [47:0] crInSsp;
  logic        excReq;
  logic [15:0] excCode;
  logic [63:0] excTea;
  logic [47:0] excPc;
  logic        irqReq;
  logic [3:0]  irqLevel;
  logic        rteReq;
  logic [47:0] regInPc;
  logic [47:0] regInSpc;
  logic [47:0] regInSsp;
  logic [63:0] regInSr;
  logic [63:0] regInExsr;
  logic [63:0] regInTea;
  logic        excAck;
  logic        excFlush;
  logic        excBusy;
  logic        excLoad;

  modport master (
    output hold, pcNext, crInPc, crInSpc, crInVbr, crInSr, crInExsr, crInTea, crInSsp,
    output excReq, excCode, excTea, excPc, irqReq, irqLevel, rteReq,
    input  regInPc, regInSpc, regInSsp, regInSr, regInExsr, regInTea,
    input  excAck, excFlush, excBusy, excLoad
  );

  modport slave (
    input  hold, pcNext, crInPc, crInSpc, crInVbr, crInSr, crInExsr, crInTea, crInSsp,
    input  excReq, excCode, excTea, excPc, irqReq, irqLevel, rteReq,
    output regInPc, regInSpc, regInSsp, regInSr, regInExsr, regInTea,
    output excAck, excFlush, excBusy, excLoad
  );
endinterface

// File: rtl/exc_seq.sv
// Exception / interrupt / return-from-exception sequencer: accepts one request, drains the
// pipeline for DRAIN cycles, then spends one cycle redirecting through the control-register file.
module exc_seq #(
  parameter int DRAIN = 3
) (
  input logic   clock,
  input logic   reset,
  exc_seq_if.slave bus
);

  typedef enum logic [1:0] {
    sIdle,
    sDrain,
    sEnter,
    sRestore
  } state_t;

  typedef enum logic {
    opEnter,
    opRestore
  } op_t;

  localparam logic [3:0]  DrainLoad = 4'(DRAIN - 1);
  localparam logic [15:0] DoubleFaultCode = 16'hF000;
  localparam logic [63:0] EnterSrBits = 64'h0000_0000_7000_0000;

  state_t      state;
  state_t      stateNext;
  op_t         op;
  logic [3:0]  count;
  logic        ackPend;
  logic [15:0] latchCode;
  logic [63:0] latchTea;
  logic [47:0] latchPc;
  logic [63:0] latchSr;

  logic        irqOk;
  logic        acceptExc;
  logic        acceptIrq;
  logic        acceptRte;
  logic        accept;

  // Interrupts are masked by SR.BL (bit 28) and by the current priority in SR[7:4].
  assign irqOk     = bus.irqReq && !bus.crInSr[28] && (bus.irqLevel > bus.crInSr[7:4]);
  assign acceptExc = (state == sIdle) && bus.excReq;
  assign acceptIrq = (state == sIdle) && !bus.excReq && irqOk;
  assign acceptRte = (state == sIdle) && !bus.excReq && !irqOk && bus.rteReq;
  assign accept    = acceptExc || acceptIrq || acceptRte;

  always_comb begin
    stateNext = state;
    unique case (state)
      sIdle:    if (accept) stateNext = sDrain;
      sDrain:   if (count == 4'd0) stateNext = (op == opEnter) ? sEnter : sRestore;
      sEnter:   stateNext = sIdle;
      sRestore: stateNext = sIdle;
      default:  stateNext = sIdle;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the values from before this edge regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      // NOTE: the latches are plain flops, not a memory, so clearing them costs nothing
      // and keeps the redirect values deterministic after reset.
      state     <= sIdle;
      op        <= opEnter;
      count     <= 4'd0;
      ackPend   <= 1'b0;
      latchCode <= 16'd0;
      latchTea  <= 64'd0;
      latchPc   <= 48'd0;
      latchSr   <= 64'd0;
    end else if (!bus.hold) begin
      state   <= stateNext;
      ackPend <= accept;
      if (accept) begin
        count   <= DrainLoad;
        latchSr <= bus.crInSr;
        if (acceptExc) begin
          op        <= opEnter;
          latchCode <= bus.crInSr[28] ? DoubleFaultCode : bus.excCode;
          latchTea  <= bus.excTea;
          latchPc   <= bus.excPc;
        end else if (acceptIrq) begin
          op        <= opEnter;
          latchCode <= {4'hE, 8'h00, bus.irqLevel};
          latchTea  <= 64'd0;
          latchPc   <= bus.crInPc;
        end else begin
          op        <= opRestore;
          latchCode <= 16'd0;
          latchTea  <= 64'd0;
          latchPc   <= bus.crInPc;
        end
      end else if (state == sDrain && count != 4'd0) begin
        count <= count - 4'd1;
      end
    end
  end

  // NOTE: every output gets a pass-through or zero default before the case, so no path
  // through this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    bus.regInPc   = bus.pcNext;
    bus.regInSpc  = bus.crInSpc;
    bus.regInSsp  = bus.crInSsp;
    bus.regInSr   = bus.crInSr;
    bus.regInExsr = bus.crInExsr;
    bus.regInTea  = bus.crInTea;
    bus.excAck    = 1'b0;
    bus.excFlush  = 1'b0;
    bus.excBusy   = 1'b0;
    bus.excLoad   = 1'b0;
    // Outputs are gated by reset so the pipeline sees a quiet sequencer while reset is low.
    if (reset) begin
      bus.excAck  = ackPend && !bus.hold;
      bus.excBusy = (state != sIdle);
      unique case (state)
        sDrain: bus.excFlush = 1'b1;
        sEnter: begin
          bus.excLoad   = 1'b1;
          bus.regInPc   = bus.crInVbr + {41'd0, latchCode[15:12], 3'd0};
          bus.regInSr   = latchSr | EnterSrBits;
          bus.regInSpc  = latchPc;
          bus.regInExsr = {latchSr[31:0], 16'h0000, latchCode};
          bus.regInTea  = latchTea;
        end
        sRestore: begin
          bus.excLoad = 1'b1;
          bus.regInPc = bus.crInSpc;
          bus.regInSr = {bus.crInSr[63:32], bus.crInExsr[63:32]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_seq.sv
// Directed bench for exc_seq (DRAIN=3): exception, interrupt masking, RTE, double fault,
// stall during drain and reset during drain, each checked against hand-computed values.
module tb_exc_seq;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  exc_seq_if busIf ();

  exc_seq #(.DRAIN(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (busIf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idleCheck(input string tag);
    check({tag, " busy"}, 64'(busIf.excBusy), 64'd0);
    check({tag, " load"}, 64'(busIf.excLoad), 64'd0);
    check({tag, " pc"}, 64'(busIf.regInPc), 64'(busIf.pcNext));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    busIf.hold     = 1'b0;
    busIf.pcNext   = 48'h0000_0000_0ABC;
    busIf.crInPc   = 48'h0000_0000_0AB8;
    busIf.crInSpc  = 48'h0000_0000_7777;
    busIf.crInVbr  = 48'h0000_0000_8000;
    busIf.crInSr   = 64'd0;
    busIf.crInExsr = 64'h1111_2222_3333_4444;
    busIf.crInTea  = 64'h0000_0000_0000_0BAD;
    busIf.crInSsp  = 48'h0000_0000_5555;
    busIf.excReq   = 1'b0;
    busIf.excCode  = 16'd0;
    busIf.excTea   = 64'd0;
    busIf.excPc    = 48'd0;
    busIf.irqReq   = 1'b0;
    busIf.irqLevel = 4'd0;
    busIf.rteReq   = 1'b0;

    // Reset: requests ignored, outputs quiet, register inputs passed through.
    busIf.excReq = 1'b1;
    cyc();
    cyc();
    check("rst ack", 64'(busIf.excAck), 64'd0);
    check("rst flush", 64'(busIf.excFlush), 64'd0);
    check("rst busy", 64'(busIf.excBusy), 64'd0);
    check("rst load", 64'(busIf.excLoad), 64'd0);
    check("rst pc", 64'(busIf.regInPc), 64'h0ABC);
    check("rst sr", busIf.regInSr, 64'd0);
    check("rst exsr", busIf.regInExsr, 64'h1111_2222_3333_4444);
    check("rst tea", busIf.regInTea, 64'h0BAD);
    check("rst ssp", 64'(busIf.regInSsp), 64'h5555);
    check("rst spc", 64'(busIf.regInSpc), 64'h7777);
    busIf.excReq = 1'b0;
    reset = 1'b1;
    cyc();
    idleCheck("post-rst");

    // Exception entry, code 3004.
    busIf.excReq  = 1'b1;
    busIf.excCode = 16'h3004;
    busIf.excPc   = 48'h1000;
    busIf.excTea  = 64'h0000_0000_0000_DEAD;
    cyc();
    check("A ack", 64'(busIf.excAck), 64'd1);
    check("A flush1", 64'(busIf.excFlush), 64'd1);
    check("A busy", 64'(busIf.excBusy), 64'd1);
    check("A load1", 64'(busIf.excLoad), 64'd0);
    busIf.excReq = 1'b0;
    cyc();
    check("A ack2", 64'(busIf.excAck), 64'd0);
    check("A flush2", 64'(busIf.excFlush), 64'd1);
    cyc();
    check("A flush3", 64'(busIf.excFlush), 64'd1);
    check("A load3", 64'(busIf.excLoad), 64'd0);
    cyc();
    check("A enter load", 64'(busIf.excLoad), 64'd1);
    check("A enter flush", 64'(busIf.excFlush), 64'd0);
    check("A enter pc", 64'(busIf.regInPc), 64'h8018);
    check("A enter sr", busIf.regInSr, 64'h0000_0000_7000_0000);
    check("A enter spc", 64'(busIf.regInSpc), 64'h1000);
    check("A enter exsr", busIf.regInExsr, 64'h0000_0000_0000_3004);
    check("A enter tea", busIf.regInTea, 64'hDEAD);
    check("A enter ssp", 64'(busIf.regInSsp), 64'h5555);
    cyc();
    idleCheck("A done");

    // Interrupt level 5 masked by SR[7:4]=6, then accepted with SR[7:4]=2.
    busIf.crInSr   = 64'h60;
    busIf.irqReq   = 1'b1;
    busIf.irqLevel = 4'd5;
    busIf.crInPc   = 48'h4444;
    cyc();
    check("B masked ack", 64'(busIf.excAck), 64'd0);
    check("B masked busy", 64'(busIf.excBusy), 64'd0);
    busIf.crInSr = 64'h20;
    cyc();
    check("B ack", 64'(busIf.excAck), 64'd1);
    busIf.irqReq = 1'b0;
    cyc();
    cyc();
    cyc();
    check("B enter load", 64'(busIf.excLoad), 64'd1);
    check("B enter exsr", busIf.regInExsr, 64'h0000_0020_0000_E005);
    check("B enter tea", busIf.regInTea, 64'd0);
    check("B enter pc", 64'(busIf.regInPc), 64'h8070);
    check("B enter spc", 64'(busIf.regInSpc), 64'h4444);
    check("B enter sr", busIf.regInSr, 64'h0000_0000_7000_0020);
    cyc();
    idleCheck("B done");

    // Return from exception.
    busIf.crInSpc  = 48'h2222;
    busIf.crInExsr = 64'h0000_00A0_1234_5678;
    busIf.crInSr   = 64'h0000_0001_0000_0000;
    busIf.rteReq   = 1'b1;
    cyc();
    check("C ack", 64'(busIf.excAck), 64'd1);
    busIf.rteReq = 1'b0;
    cyc();
    cyc();
    check("C drain load", 64'(busIf.excLoad), 64'd0);
    cyc();
    check("C restore load", 64'(busIf.excLoad), 64'd1);
    check("C restore pc", 64'(busIf.regInPc), 64'h2222);
    check("C restore sr", busIf.regInSr, 64'h0000_0001_0000_00A0);
    check("C restore exsr", busIf.regInExsr, 64'h0000_00A0_1234_5678);
    cyc();
    idleCheck("C done");

    // Double fault with simultaneous irq and rte: exception wins, code forced to F000.
    busIf.crInSr   = 64'h0000_0000_1000_0000;
    busIf.excReq   = 1'b1;
    busIf.excCode  = 16'h2008;
    busIf.irqReq   = 1'b1;
    busIf.irqLevel = 4'hF;
    busIf.rteReq   = 1'b1;
    cyc();
    check("D ack", 64'(busIf.excAck), 64'd1);
    busIf.excReq = 1'b0;
    busIf.irqReq = 1'b0;
    busIf.rteReq = 1'b0;
    cyc();
    cyc();
    cyc();
    check("D enter load", 64'(busIf.excLoad), 64'd1);
    check("D enter exsr", busIf.regInExsr, 64'h1000_0000_0000_F000);
    check("D enter pc", 64'(busIf.regInPc), 64'h8078);
    check("D enter sr", busIf.regInSr, 64'h0000_0000_7000_0000);
    cyc();
    idleCheck("D done");
    cyc();
    check("D no rte ack", 64'(busIf.excAck), 64'd0);
    check("D no rte busy", 64'(busIf.excBusy), 64'd0);

    // Stall for 4 cycles in the middle of the drain delays ENTER by exactly 4 cycles.
    busIf.crInSr  = 64'd0;
    busIf.excReq  = 1'b1;
    busIf.excCode = 16'h1000;
    busIf.excPc   = 48'h3000;
    cyc();
    busIf.excReq = 1'b0;
    cyc();
    busIf.hold = 1'b1;
    settle();
    check("E hold ack", 64'(busIf.excAck), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check($sformatf("E hold%0d flush", i), 64'(busIf.excFlush), 64'd1);
      check($sformatf("E hold%0d load", i), 64'(busIf.excLoad), 64'd0);
    end
    busIf.hold = 1'b0;
    cyc();
    check("E post-hold load", 64'(busIf.excLoad), 64'd0);
    check("E post-hold flush", 64'(busIf.excFlush), 64'd1);
    cyc();
    check("E enter load", 64'(busIf.excLoad), 64'd1);
    check("E enter pc", 64'(busIf.regInPc), 64'h8008);
    check("E enter spc", 64'(busIf.regInSpc), 64'h3000);
    cyc();
    idleCheck("E done");

    // Reset during drain abandons the operation with no redirect cycle.
    busIf.excReq  = 1'b1;
    busIf.excCode = 16'h5000;
    cyc();
    busIf.excReq = 1'b0;
    reset = 1'b0;
    settle();
    check("F rst flush", 64'(busIf.excFlush), 64'd0);
    check("F rst busy", 64'(busIf.excBusy), 64'd0);
    cyc();
    reset = 1'b1;
    settle();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("F after%0d load", i), 64'(busIf.excLoad), 64'd0);
      check($sformatf("F after%0d busy", i), 64'(busIf.excBusy), 64'd0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
